// File: rtl/keypad_scanner_if.sv
// Keypad matrix signal bundle: row drive and column sense toward the keypad,
// plus the debounced key result toward the consumer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    output row,
    output key,
    output key_valid,
    output key_held,
    input  col
  );

  modport slave (
    input  row,
    input  key,
    input  key_valid,
    input  key_held,
    output col
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low row strobe, samples synchronized
// columns, debounces whole-scan results and strobes each accepted key press once.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int DEBOUNCE_SCANS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_scanner_if.master   kp
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX      = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ST_START, ST_DRIVE, ST_SAMPLE} state_t;
  typedef enum logic [1:0] {CAND_NONE, CAND_CODE, CAND_INVALID} cand_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [15:0]   acc, acc_n;
  logic [3:0]    row_q, row_n;
  logic          scan_done;

  logic [3:0]    col_meta, col_sync;
  logic [DW-1:0] db_cnt, db_next;
  cand_t         prev_kind, cand_kind;
  logic [3:0]    prev_code, cand_code;
  logic [4:0]    ones;
  logic          same, accept_press, accept_release;
  logic [3:0]    key_q;
  logic          valid_q, held_q;

  // Columns are asynchronous to clk; only the second flop is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= kp.col;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_START;
      cnt     <= '0;
      row_idx <= 2'd0;
      acc     <= '0;
      row_q   <= 4'hF;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      row_idx <= row_idx_n;
      acc     <= acc_n;
      row_q   <= row_n;
    end
  end

  // Row drive is registered from the next state so it never glitches.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_idx_n = row_idx;
    acc_n     = acc;
    scan_done = 1'b0;
    case (state)
      ST_START: begin
        state_n = ST_DRIVE;
        cnt_n   = SETTLE_LOAD;
      end
      ST_DRIVE: begin
        if (cnt == '0) state_n = ST_SAMPLE;
        else           cnt_n   = cnt - CW'(1);
      end
      ST_SAMPLE: begin
        acc_n[{row_idx, 2'b00} +: 4] = ~col_sync;
        row_idx_n = row_idx + 2'd1;
        state_n   = ST_DRIVE;
        cnt_n     = SETTLE_LOAD;
        scan_done = (row_idx == 2'd3);
      end
      default: state_n = ST_START;
    endcase
    row_n = (state_n == ST_START) ? 4'hF : ~(4'b0001 << row_idx_n);
  end

  // Classify the completed scan; acc_n already holds the freshly sampled row 3.
  always_comb begin
    ones      = 5'd0;
    cand_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (acc_n[i]) begin
        ones      = ones + 5'd1;
        cand_code = 4'(i);
      end
    end
    if (ones == 5'd0)      cand_kind = CAND_NONE;
    else if (ones == 5'd1) cand_kind = CAND_CODE;
    else                   cand_kind = CAND_INVALID;
    same = (cand_kind == prev_kind) &&
           ((cand_kind != CAND_CODE) || (cand_code == prev_code));
    if (!same)               db_next = DW'(1);
    else if (db_cnt == DB_MAX) db_next = db_cnt;
    else                     db_next = db_cnt + DW'(1);
    accept_press   = scan_done && !held_q && (db_next == DB_MAX) && (cand_kind == CAND_CODE);
    accept_release = scan_done &&  held_q && (db_next == DB_MAX) && (cand_kind == CAND_NONE);
  end

  // A held key blocks any other code until a debounced release is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      prev_kind <= CAND_NONE;
      prev_code <= 4'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (scan_done) begin
        db_cnt    <= db_next;
        prev_kind <= cand_kind;
        prev_code <= cand_code;
      end
      if (accept_press) begin
        key_q   <= cand_code;
        held_q  <= 1'b1;
        valid_q <= 1'b1;
      end else if (accept_release) begin
        held_q  <= 1'b0;
      end
    end
  end

  assign kp.row       = row_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, strobe scoreboard,
// row-sequence, bounce, multi-press, release and async-reset scenarios.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEBNC  = 3;
  localparam int SCAN   = 4 * (SETTLE + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  col_v;
  logic [3:0]  exp_row;
  logic        prev_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          strobe_count = 0;
  int          start_cnt;
  int          waited;
  logic [3:0]  exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEBNC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kif)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed switch pulls its column low while its row is driven.
  always_comb begin
    col_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.row[r]) col_v[c] = 1'b0;
  end
  assign kif.col = col_v;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    @(negedge clk);
    pressed = keys;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitStrobe(input int max_cycles, input string tag);
    int base;
    bit seen;
    base = strobe_count;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      #1;
      if (strobe_count != base) seen = 1'b1;
    end
    checkOutput(tag, seen, 1);
  endtask

  // Every strobe must match the oldest outstanding expected key.
  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      strobe_count <= strobe_count + 1;
      if (exp_q.size() == 0) checkOutput("spurious_strobe", 1, 0);
      else begin
        checkOutput("strobe_key", kif.key, exp_q.pop_front());
        checkOutput("strobe_held", kif.key_held, 1);
      end
      checkOutput("strobe_back_to_back", prev_valid, 0);
    end
    prev_valid <= rst_n && kif.key_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_row", kif.row, 4'hF);
    checkOutput("rst_key", kif.key, 0);
    checkOutput("rst_valid", kif.key_valid, 0);
    checkOutput("rst_held", kif.key_held, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      exp_row = 4'hF;
      exp_row[(k / (SETTLE + 1)) % 4] = 1'b0;
      checkOutput("row_sequence", kif.row, exp_row);
    end
    checkOutput("t1_no_strobe", strobe_count, 0);

    // Bounce: never stable for enough scans.
    start_cnt = strobe_count;
    applyStimulus(16'h0001, 2 * SCAN);
    applyStimulus(16'h0000, 2 * SCAN);
    applyStimulus(16'h0001, SCAN);
    applyStimulus(16'h0000, 2 * SCAN);
    checkOutput("bounce_no_strobe", strobe_count - start_cnt, 0);
    checkOutput("bounce_held", kif.key_held, 0);

    // Two keys together resolve to an invalid scan.
    start_cnt = strobe_count;
    applyStimulus(16'h0042, 10 * SCAN);
    checkOutput("multi_no_strobe", strobe_count - start_cnt, 0);
    checkOutput("multi_held", kif.key_held, 0);
    applyStimulus(16'h0000, 4 * SCAN);

    // Single press of row 2 / col 1.
    exp_q.push_back(4'h9);
    applyStimulus(16'h0200, 0);
    waitStrobe(4 * SCAN + 3, "press9_latency");
    start_cnt = strobe_count;
    applyStimulus(16'h0200, 20 * SCAN);
    checkOutput("press9_no_repeat", strobe_count - start_cnt, 0);
    checkOutput("press9_held", kif.key_held, 1);

    // Adding a second key while one is held is ignored.
    start_cnt = strobe_count;
    applyStimulus(16'h0204, 10 * SCAN);
    checkOutput("switch_key", kif.key, 4'h9);
    checkOutput("switch_held", kif.key_held, 1);
    checkOutput("switch_no_strobe", strobe_count - start_cnt, 0);

    // Release: still held after two none scans, dropped within a few more.
    applyStimulus(16'h0000, 2 * SCAN);
    checkOutput("release_not_early", kif.key_held, 1);
    waited = 0;
    while (kif.key_held && waited < 3 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("release_held", kif.key_held, 0);
    checkOutput("release_key_kept", kif.key, 4'h9);
    applyStimulus(16'h0000, SCAN);

    // New key after release.
    exp_q.push_back(4'hF);
    applyStimulus(16'h8000, 0);
    waitStrobe(4 * SCAN + 3, "pressF_latency");
    applyStimulus(16'h8000, 2 * SCAN);
    checkOutput("pressF_held", kif.key_held, 1);

    // Asynchronous reset while the key is still held.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_row", kif.row, 4'hF);
    checkOutput("arst_held", kif.key_held, 0);
    checkOutput("arst_valid", kif.key_valid, 0);
    checkOutput("arst_key", kif.key, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    exp_q.push_back(4'hF);
    start_cnt = strobe_count;
    repeat (45) @(negedge clk);
    checkOutput("rearm_not_early", strobe_count - start_cnt, 0);
    waitStrobe(2 * SCAN, "rearm_strobe");
    applyStimulus(16'h8000, SCAN);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
